// File: rtl/xnor_serial_cmp_arb.sv
// Round-robin, bit-serial equality compare through one shared external xnor2 cell.
// Latency: ACK in the cycle after capture, DONE W+1 cycles after capture (earlier with EARLY_EXIT).
// Backpressure: requests arriving while BUSY stay pending and are evaluated in the next IDLE cycle.
module xnor_serial_cmp_arb #(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         REQ0,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic         REQ1,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  output logic         ACK0,
  output logic         ACK1,
  output logic         XN_A1,
  output logic         XN_A2,
  input  logic         XN_ZN,
  output logic         BUSY,
  output logic         DONE,
  output logic         DONE_ID,
  output logic         EQ
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           pri_q;
  logic           own_q;
  logic           acc_q, acc_d;
  logic           ack0_q, ack1_q;
  logic           xa_q, xb_q;
  logic           eq_q, id_q;
  logic [W-1:0]   sha_q, shb_q;
  logic [CW-1:0]  cnt_q;

  logic           any_req;
  logic           winner;
  logic           last_bit;
  logic           early_miss;

  // Arbitration and RUN-cycle decode
  always_comb begin
    any_req    = REQ0 | REQ1;
    // Sole requester wins; on contention the priority pointer decides.
    winner     = (REQ0 && REQ1) ? pri_q : REQ1;
    last_bit   = (cnt_q == CW'(W - 1));
    early_miss = EARLY_EXIT && !XN_ZN;
    acc_d      = acc_q & XN_ZN;
  end

  // State register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_RUN;
      S_RUN:   if (last_bit || early_miss) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture, bit shifting, accumulation and result holding
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      pri_q  <= 1'b0;
      own_q  <= 1'b0;
      acc_q  <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      xa_q   <= 1'b0;
      xb_q   <= 1'b0;
      eq_q   <= 1'b0;
      id_q   <= 1'b0;
      sha_q  <= '0;
      shb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          xa_q <= 1'b0;
          xb_q <= 1'b0;
          if (any_req) begin
            sha_q  <= winner ? A1 : A0;
            shb_q  <= winner ? B1 : B0;
            xa_q   <= winner ? A1[0] : A0[0];
            xb_q   <= winner ? B1[0] : B0[0];
            own_q  <= winner;
            pri_q  <= ~winner;
            cnt_q  <= '0;
            acc_q  <= 1'b1;
            ack0_q <= ~winner;
            ack1_q <= winner;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          sha_q <= sha_q >> 1;
          shb_q <= shb_q >> 1;
          xa_q  <= sha_q[1];
          xb_q  <= shb_q[1];
          if (state_d == S_DONE) begin
            // Cell inputs park low for DONE; result and owner latch until the next DONE.
            xa_q <= 1'b0;
            xb_q <= 1'b0;
            eq_q <= acc_d;
            id_q <= own_q;
          end
        end
        default: begin
          xa_q <= 1'b0;
          xb_q <= 1'b0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    ACK0    = ack0_q;
    ACK1    = ack1_q;
    XN_A1   = xa_q;
    XN_A2   = xb_q;
    BUSY    = (state_q != S_IDLE);
    DONE    = (state_q == S_DONE);
    DONE_ID = id_q;
    EQ      = eq_q;
  end

endmodule

// File: tb/tb_xnor_serial_cmp_arb.sv
// Directed bench for xnor_serial_cmp_arb: one instance without and one with early exit.
// Each instance drives its own behavioural xnor2 model with an optional stuck-at-0 override.
// Vector table for single compares plus hand sequences for reset, contention and mid-run reset.
module tb_xnor_serial_cmp_arb;

  logic       clk;
  logic       rn;
  logic       req0 [2];
  logic       req1 [2];
  logic [7:0] a0   [2];
  logic [7:0] b0   [2];
  logic [7:0] a1   [2];
  logic [7:0] b1   [2];
  logic       ack0 [2];
  logic       ack1 [2];
  logic       xa   [2];
  logic       xb   [2];
  logic       zn   [2];
  logic       zf   [2];
  logic       busy [2];
  logic       done [2];
  logic       did  [2];
  logic       eq   [2];

  int checks   = 0;
  int failures = 0;

  assign zn[0] = zf[0] ? 1'b0 : ~(xa[0] ^ xb[0]);
  assign zn[1] = zf[1] ? 1'b0 : ~(xa[1] ^ xb[1]);

  xnor_serial_cmp_arb #(.W(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .CLK(clk), .RN(rn),
    .REQ0(req0[0]), .A0(a0[0]), .B0(b0[0]),
    .REQ1(req1[0]), .A1(a1[0]), .B1(b1[0]),
    .ACK0(ack0[0]), .ACK1(ack1[0]),
    .XN_A1(xa[0]), .XN_A2(xb[0]), .XN_ZN(zn[0]),
    .BUSY(busy[0]), .DONE(done[0]), .DONE_ID(did[0]), .EQ(eq[0])
  );

  xnor_serial_cmp_arb #(.W(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .CLK(clk), .RN(rn),
    .REQ0(req0[1]), .A0(a0[1]), .B0(b0[1]),
    .REQ1(req1[1]), .A1(a1[1]), .B1(b1[1]),
    .ACK0(ack0[1]), .ACK1(ack1[1]),
    .XN_A1(xa[1]), .XN_A2(xb[1]), .XN_ZN(zn[1]),
    .BUSY(busy[1]), .DONE(done[1]), .DONE_ID(did[1]), .EQ(eq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int inst, input bit id);
    return id ? ack1[inst] : ack0[inst];
  endfunction

  // Drive one request and follow it to DONE. Called #1 after a rising edge.
  // ack_lat: edges until ACK seen; done_lat: edges from ACK to DONE seen (-1 on timeout).
  task automatic do_cmp(input int inst, input bit id, input logic [7:0] a, input logic [7:0] b,
                        input int fault_k, output int ack_lat, output int done_lat,
                        output logic r_eq, output logic r_id,
                        output logic [7:0] seq_a, output logic [7:0] seq_b);
    int  n;
    bit  got;
    seq_a = 8'h00;
    seq_b = 8'h00;
    if (id) begin a1[inst] = a; b1[inst] = b; req1[inst] = 1'b1; end
    else    begin a0[inst] = a; b0[inst] = b; req0[inst] = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack_of(inst, id)) got = 1'b1;
    end
    ack_lat = got ? n : -1;
    if (id) req1[inst] = 1'b0; else req0[inst] = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      if (n < 8) begin
        seq_a[n] = xa[inst];
        seq_b[n] = xb[inst];
      end
      zf[inst] = (n == fault_k);
      @(posedge clk); #1;
      n++;
      if (done[inst]) got = 1'b1;
    end
    zf[inst] = 1'b0;
    done_lat = got ? n : -1;
    r_eq = eq[inst];
    r_id = did[inst];
  endtask

  typedef struct {
    int         inst;
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    int         fault_k;
    logic       exp_eq;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int         g_edge [8];
    int         g_id   [8];
    int         d_id   [8];
    int         ng, nd, dn;
    int         al, dl;
    logic       req, rid;
    logic [7:0] sa, sb;

    vecs[0] = '{0, 1'b0, 8'hA5, 8'hA5, -1, 1'b1, 8};
    vecs[1] = '{0, 1'b1, 8'h80, 8'h00, -1, 1'b0, 8};
    vecs[2] = '{1, 1'b1, 8'h80, 8'h00, -1, 1'b0, 8};
    vecs[3] = '{1, 1'b0, 8'h01, 8'h00, -1, 1'b0, 1};
    vecs[4] = '{0, 1'b0, 8'hA5, 8'hA5,  5, 1'b0, 8};
    vecs[5] = '{1, 1'b0, 8'hA5, 8'hA5,  5, 1'b0, 6};
    vecs[6] = '{0, 1'b1, 8'hFF, 8'hFF, -1, 1'b1, 8};
    vecs[7] = '{0, 1'b0, 8'h00, 8'h01, -1, 1'b0, 8};
    vecs[8] = '{1, 1'b1, 8'h3C, 8'h3C, -1, 1'b1, 8};
    vecs[9] = '{1, 1'b0, 8'h10, 8'h00, -1, 1'b0, 5};

    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; zf[i] = 1'b0;
      a0[i] = 8'h00; b0[i] = 8'h00; a1[i] = 8'h00; b1[i] = 8'h00;
    end

    // Reset with both requests high on instance 0: every output stays low.
    rn = 1'b0;
    a0[0] = 8'h33; b0[0] = 8'h33; a1[0] = 8'hC3; b1[0] = 8'hC3;
    req0[0] = 1'b1; req1[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", ack0[0], 0);
    chk("rst_ack1", ack1[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_eq", eq[0], 0);
    chk("rst_done_id", did[0], 0);
    chk("rst_xn_a1", xa[0], 0);
    chk("rst_xn_a2", xb[0], 0);
    chk("rst_busy_ee", busy[1], 0);
    @(negedge clk);
    rn = 1'b1;

    // Continuous contention: grants alternate starting with requester 0, 10 cycles apart.
    ng = 0; nd = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      if (ack0[0] && ack1[0]) chk("dual_ack", 1, 0);
      if ((ack0[0] || ack1[0]) && ng < 8) begin
        g_edge[ng] = e; g_id[ng] = ack1[0] ? 1 : 0; ng++;
      end
      if (done[0] && nd < 8) begin
        d_id[nd] = did[0]; nd++;
      end
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("cont_grants", ng, 5);
    chk("cont_dones", nd, 5);
    chk("cont_first_edge", g_edge[0], 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant_id%0d", k), g_id[k], k % 2);
      chk($sformatf("cont_done_id%0d", k), d_id[k], k % 2);
      chk($sformatf("cont_gap%0d", k), g_edge[k+1] - g_edge[k], 10);
    end
    chk("cont_idle_after", busy[0], 0);

    // Single compares from the vector table.
    for (int i = 0; i < 10; i++) begin
      do_cmp(vecs[i].inst, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fault_k,
             al, dl, req, rid, sa, sb);
      chk($sformatf("v%0d_ack_lat", i), al, 1);
      chk($sformatf("v%0d_done_lat", i), dl, vecs[i].exp_lat);
      chk($sformatf("v%0d_eq", i), req, vecs[i].exp_eq);
      chk($sformatf("v%0d_done_id", i), rid, vecs[i].id);
      chk($sformatf("v%0d_done_busy", i), busy[vecs[i].inst], 1);
      chk($sformatf("v%0d_done_xn", i), xa[vecs[i].inst] | xb[vecs[i].inst], 0);
      if (vecs[i].inst == 0) begin
        chk($sformatf("v%0d_seq_a1", i), sa, vecs[i].a);
        chk($sformatf("v%0d_seq_a2", i), sb, vecs[i].b);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done[vecs[i].inst], 0);
      chk($sformatf("v%0d_idle", i), busy[vecs[i].inst], 0);
      chk($sformatf("v%0d_eq_hold", i), eq[vecs[i].inst], vecs[i].exp_eq);
      chk($sformatf("v%0d_id_hold", i), did[vecs[i].inst], vecs[i].id);
    end

    // Reset in RUN cycle 3 aborts; the still-held request is re-granted afterwards.
    a1[0] = 8'h5A; b1[0] = 8'h5A; req1[0] = 1'b1;
    dn = 0;
    while (!ack1[0] && dn < 20) begin
      @(posedge clk); #1;
      dn++;
    end
    chk("mr_ack_seen", ack1[0], 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_busy_before", busy[0], 1);
    rn = 1'b0;
    #1;
    chk("mr_busy_drop", busy[0], 0);
    chk("mr_done_drop", done[0], 0);
    dn = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) dn++;
    end
    chk("mr_quiet", dn, 0);
    @(negedge clk);
    rn = 1'b1;
    do_cmp(0, 1'b1, 8'h5A, 8'h5A, -1, al, dl, req, rid, sa, sb);
    chk("mr_regrant_lat", al, 1);
    chk("mr_done_lat", dl, 8);
    chk("mr_eq", req, 1);
    chk("mr_done_id", rid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
